// File: rtl/saturate_pkg.sv
// Shared types for the rounding/saturating output pipeline.
package saturate_pkg;

   typedef enum logic [1:0] {
      ROUND_TRUNC     = 2'd0,
      ROUND_HALF_UP   = 2'd1,
      ROUND_HALF_EVEN = 2'd2,
      ROUND_RSVD      = 2'd3
   } round_mode_t;

endpackage

// File: rtl/saturate_pipe_round_shift.sv
// Combinational rounding right-shift: r = floor((x + bias) / 2^FRAC), one bit wider than kept part.
module round_shift
   import saturate_pkg::*;
#(
   parameter int unsigned IW   = 17,
   parameter int unsigned FRAC = 0
) (
   input  logic [IW-1:0]   i_x,
   input  round_mode_t     i_mode,
   output logic [IW-FRAC:0] o_r
);

   if (FRAC == 0) begin : g_pass
      logic w_unused_mode;
      assign w_unused_mode = ^i_mode;
      assign o_r           = {i_x[IW-1], i_x};
   end else begin : g_round
      localparam logic [IW:0] Half = (IW+1)'(1) << (FRAC-1);

      logic [IW:0]     w_bias;
      logic [FRAC-1:0] w_unused_lsb;

      always_comb begin
         w_bias = '0;
         case (i_mode)
            ROUND_HALF_UP:   w_bias = Half;
            // Exact tie onto an even kept value rounds down instead of up.
            ROUND_HALF_EVEN: w_bias = (!i_x[FRAC] && (i_x[FRAC-1:0] == Half[FRAC-1:0])) ?
                                      Half - 1'b1 : Half;
            default:         w_bias = '0;
         endcase
      end

      // One guard bit above IW keeps x + bias from wrapping.
      assign {o_r, w_unused_lsb} = {i_x[IW-1], i_x} + w_bias;
   end

endmodule

// File: rtl/saturate_pipe.sv
// Two-stage valid/ready pipeline: round-shift a signed value, then clamp it to OW bits,
// with sticky and counted saturation statistics on delivered results.
module saturate_pipe
   import saturate_pkg::*;
#(
   parameter int unsigned IW   = 17,
   parameter int unsigned OW   = 16,
   parameter int unsigned FRAC = 0,
   parameter int unsigned CW   = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          arg_valid,
   output logic          arg_ready,
   input  logic [IW-1:0] arg_data,
   input  logic [1:0]    arg_mode,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [OW-1:0] res_data,
   output logic          res_sat,
   input  logic          clear,
   output logic          sat_flag,
   output logic [CW-1:0] sat_count
);

   localparam int unsigned RW = IW - FRAC + 1;

   if (IW < FRAC + OW) begin : g_param_err
      $error("saturate_pipe: IW-FRAC must be >= OW");
   end

   localparam logic signed [RW-1:0] SatMax = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [RW-1:0] SatMin = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   round_mode_t          w_mode;
   logic [RW-1:0]        w_r;
   logic                 w_s1_en;
   logic                 w_s2_en;
   logic                 w_evt;
   logic [OW-1:0]        w_sat_data;
   logic                 w_sat;

   logic                 r_s1_valid;
   logic signed [RW-1:0] r_s1_r;
   logic                 r_res_valid;
   logic [OW-1:0]        r_res_data;
   logic                 r_res_sat;
   logic                 r_sat_flag;
   logic [CW-1:0]        r_sat_count;

   assign w_mode    = round_mode_t'(arg_mode);
   assign w_s2_en   = !r_res_valid || res_ready;
   assign w_s1_en   = !r_s1_valid || w_s2_en;
   assign arg_ready = w_s1_en;
   assign w_evt     = r_res_valid && res_ready && r_res_sat;

   round_shift #(
      .IW   (IW),
      .FRAC (FRAC)
   ) u_round_shift (
      .i_x    (arg_data),
      .i_mode (w_mode),
      .o_r    (w_r)
   );

   always_comb begin
      w_sat_data = r_s1_r[OW-1:0];
      w_sat      = 1'b0;
      if (r_s1_r > SatMax) begin
         w_sat_data = SatMax[OW-1:0];
         w_sat      = 1'b1;
      end else if (r_s1_r < SatMin) begin
         w_sat_data = SatMin[OW-1:0];
         w_sat      = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_s1_en && arg_valid) begin
         r_s1_r <= w_r;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_sat   <= 1'b0;
      end else begin
         if (w_s1_en) begin
            r_s1_valid <= arg_valid;
         end
         if (w_s2_en) begin
            r_res_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_res_data <= w_sat_data;
               r_res_sat  <= w_sat;
            end
         end
      end
   end

   // A clamped delivery coinciding with clear counts as the first event after clearing.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sat_flag  <= 1'b0;
         r_sat_count <= '0;
      end else if (clear) begin
         r_sat_flag  <= w_evt;
         r_sat_count <= w_evt ? CW'(1) : '0;
      end else if (w_evt) begin
         r_sat_flag <= 1'b1;
         if (r_sat_count != '1) begin
            r_sat_count <= r_sat_count + 1'b1;
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_sat   = r_res_sat;
   assign sat_flag  = r_sat_flag;
   assign sat_count = r_sat_count;

endmodule

// File: tb/tb_saturate_pipe.sv
// Bench for saturate_pipe: a default instance (A) and an IW=20/FRAC=4/CW=2 instance (B),
// each checked every cycle against an arithmetic reference model and a result queue.
module tb_saturate_pipe;

   typedef struct packed {
      logic [15:0] d;
      logic        s;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic        a_arg_valid = 0, a_arg_ready, a_res_valid, a_res_ready = 1, a_res_sat;
   logic        a_clear = 0, a_sat_flag;
   logic [16:0] a_arg_data = '0;
   logic [1:0]  a_arg_mode = '0;
   logic [15:0] a_res_data;
   logic [7:0]  a_sat_count;

   logic        b_arg_valid = 0, b_arg_ready, b_res_valid, b_res_ready = 1, b_res_sat;
   logic        b_clear = 0, b_sat_flag;
   logic [19:0] b_arg_data = '0;
   logic [1:0]  b_arg_mode = '0;
   logic [15:0] b_res_data;
   logic [1:0]  b_sat_count;

   saturate_pipe #(.IW(17), .OW(16), .FRAC(0), .CW(8)) u_a (
      .clock(clock), .reset(reset), .arg_valid(a_arg_valid), .arg_ready(a_arg_ready),
      .arg_data(a_arg_data), .arg_mode(a_arg_mode), .res_valid(a_res_valid),
      .res_ready(a_res_ready), .res_data(a_res_data), .res_sat(a_res_sat), .clear(a_clear),
      .sat_flag(a_sat_flag), .sat_count(a_sat_count)
   );

   saturate_pipe #(.IW(20), .OW(16), .FRAC(4), .CW(2)) u_b (
      .clock(clock), .reset(reset), .arg_valid(b_arg_valid), .arg_ready(b_arg_ready),
      .arg_data(b_arg_data), .arg_mode(b_arg_mode), .res_valid(b_res_valid),
      .res_ready(b_res_ready), .res_data(b_res_data), .res_sat(b_res_sat), .clear(b_clear),
      .sat_flag(b_sat_flag), .sat_count(b_sat_count)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Reference: sign-extend, add the mode's bias, floor-divide, then clamp to 16 bits.
   function automatic exp_t model(input logic [31:0] raw, input int iw, input int frac,
                                  input int mode);
      longint x, half, bias, r;
      exp_t   e;
      x = longint'(raw);
      if (raw[iw-1]) x = x - (longint'(1) <<< iw);
      bias = 0;
      if (frac > 0 && (mode == 1 || mode == 2)) begin
         half = longint'(1) <<< (frac - 1);
         bias = half;
         if (mode == 2 && (x & (2 * half - 1)) == half && ((x >>> frac) & 1) == 0)
            bias = half - 1;
      end
      r = (x + bias) >>> frac;
      e.s = 1'b1;
      if (r > 32767) e.d = 16'h7fff;
      else if (r < -32768) e.d = 16'h8000;
      else begin
         e.d = r[15:0];
         e.s = 1'b0;
      end
      return e;
   endfunction

   exp_t        qa[$], qb[$];
   logic        a_flag_m = 0, b_flag_m = 0, a_hold_v = 0, b_hold_v = 0;
   int          a_cnt_m = 0, b_cnt_m = 0;
   logic [16:0] a_hold_d, b_hold_d;

   always @(negedge clock) begin
      exp_t e;
      logic evt;
      if (reset) begin
         qa.delete();
         a_flag_m = 0; a_cnt_m = 0; a_hold_v = 0;
      end else begin
         check("a_sat_flag", a_sat_flag, a_flag_m);
         check("a_sat_count", a_sat_count, a_cnt_m);
         if (a_hold_v) begin
            check("a_stall_valid", a_res_valid, 1);
            check("a_stall_data", {a_res_sat, a_res_data}, a_hold_d);
         end
         a_hold_v = a_res_valid && !a_res_ready;
         a_hold_d = {a_res_sat, a_res_data};
         if (a_arg_valid && a_arg_ready) qa.push_back(model(32'(a_arg_data), 17, 0, a_arg_mode));
         evt = 0;
         if (a_res_valid && a_res_ready) begin
            if (qa.size() == 0) check("a_unexpected_result", a_res_data, 'x);
            else begin
               e = qa.pop_front();
               check("a_res_data", a_res_data, e.d);
               check("a_res_sat", a_res_sat, e.s);
               evt = e.s;
            end
         end
         if (a_clear) begin a_flag_m = evt; a_cnt_m = evt ? 1 : 0; end
         else if (evt) begin a_flag_m = 1; if (a_cnt_m < 255) a_cnt_m++; end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      logic evt;
      if (reset) begin
         qb.delete();
         b_flag_m = 0; b_cnt_m = 0; b_hold_v = 0;
      end else begin
         check("b_sat_flag", b_sat_flag, b_flag_m);
         check("b_sat_count", b_sat_count, b_cnt_m);
         if (b_hold_v) begin
            check("b_stall_valid", b_res_valid, 1);
            check("b_stall_data", {b_res_sat, b_res_data}, b_hold_d);
         end
         b_hold_v = b_res_valid && !b_res_ready;
         b_hold_d = {b_res_sat, b_res_data};
         if (b_arg_valid && b_arg_ready) qb.push_back(model(32'(b_arg_data), 20, 4, b_arg_mode));
         evt = 0;
         if (b_res_valid && b_res_ready) begin
            if (qb.size() == 0) check("b_unexpected_result", b_res_data, 'x);
            else begin
               e = qb.pop_front();
               check("b_res_data", b_res_data, e.d);
               check("b_res_sat", b_res_sat, e.s);
               evt = e.s;
            end
         end
         if (b_clear) begin b_flag_m = evt; b_cnt_m = evt ? 1 : 0; end
         else if (evt) begin b_flag_m = 1; if (b_cnt_m < 3) b_cnt_m++; end
      end
   end

   // Single item, res_ready=1: not valid one edge after acceptance, valid after the second.
   task automatic lit_a(input logic [16:0] d, input logic [1:0] m, input logic [15:0] ed,
                        input logic es);
      @(posedge clock); #1;
      a_arg_valid = 1; a_arg_data = d; a_arg_mode = m;
      @(negedge clock); check("a_lit_ready", a_arg_ready, 1);
      @(posedge clock); #1; a_arg_valid = 0;
      @(negedge clock); check("a_lit_early", a_res_valid, 0);
      @(negedge clock);
      check("a_lit_valid", a_res_valid, 1);
      check("a_lit_data", a_res_data, ed);
      check("a_lit_sat", a_res_sat, es);
   endtask

   task automatic lit_b(input logic [19:0] d, input logic [1:0] m, input logic [15:0] ed,
                        input logic es);
      @(posedge clock); #1;
      b_arg_valid = 1; b_arg_data = d; b_arg_mode = m;
      @(negedge clock); check("b_lit_ready", b_arg_ready, 1);
      @(posedge clock); #1; b_arg_valid = 0;
      @(negedge clock); check("b_lit_early", b_res_valid, 0);
      @(negedge clock);
      check("b_lit_valid", b_res_valid, 1);
      check("b_lit_data", b_res_data, ed);
      check("b_lit_sat", b_res_sat, es);
   endtask

   task automatic drain(input int which);
      for (int i = 0; i < 12 && ((which == 0) ? qa.size() : qb.size()) != 0; i++)
         @(negedge clock);
      check(which == 0 ? "a_drain" : "b_drain", (which == 0) ? qa.size() : qb.size(), 0);
   endtask

   task automatic burst_a(input int n);
      int  sent = 0, guard = 0;
      logic acc;
      @(posedge clock); #1;
      a_arg_valid = 1; a_arg_data = 17'($urandom); a_arg_mode = 2'($urandom);
      while (sent < n && guard < 2000) begin
         a_res_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock); acc = a_arg_ready;
         @(posedge clock); #1; guard++;
         if (acc) begin
            sent++;
            a_arg_data = 17'($urandom); a_arg_mode = 2'($urandom);
         end
      end
      a_arg_valid = 0; a_res_ready = 1;
      check("a_burst_sent", sent, n);
      drain(0);
   endtask

   task automatic burst_b(input int n);
      int  sent = 0, guard = 0;
      logic acc;
      @(posedge clock); #1;
      b_arg_valid = 1; b_arg_data = 20'($urandom); b_arg_mode = 2'($urandom);
      while (sent < n && guard < 2000) begin
         b_res_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock); acc = b_arg_ready;
         @(posedge clock); #1; guard++;
         if (acc) begin
            sent++;
            b_arg_data = 20'($urandom); b_arg_mode = 2'($urandom);
         end
      end
      b_arg_valid = 0; b_res_ready = 1;
      check("b_burst_sent", sent, n);
      drain(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      check("rst_a_valid", a_res_valid, 0);
      check("rst_a_data", a_res_data, 0);
      check("rst_a_sat", a_res_sat, 0);
      check("rst_a_ready", a_arg_ready, 1);
      check("rst_b_valid", b_res_valid, 0);
      check("rst_b_count", b_sat_count, 0);

      lit_a(17'h000ff, 2'd0, 16'h00ff, 0);
      lit_a(17'h1ff00, 2'd0, 16'hff00, 0);
      lit_a(17'h07fff, 2'd0, 16'h7fff, 0);
      lit_a(17'h10000, 2'd0, 16'h8000, 1);

      lit_b(20'h00018, 2'd0, 16'h0001, 0);
      lit_b(20'h00018, 2'd1, 16'h0002, 0);
      lit_b(20'h00018, 2'd2, 16'h0002, 0);
      lit_b(20'h00028, 2'd0, 16'h0002, 0);
      lit_b(20'h00028, 2'd1, 16'h0003, 0);
      lit_b(20'h00028, 2'd2, 16'h0002, 0);
      lit_b(20'hFFFE8, 2'd0, 16'hFFFE, 0);
      lit_b(20'hFFFE8, 2'd1, 16'hFFFF, 0);
      lit_b(20'hFFFE8, 2'd2, 16'hFFFE, 0);
      lit_b(20'hFFFE8, 2'd3, 16'hFFFE, 0);
      lit_b(20'h7FFF8, 2'd1, 16'h7fff, 1);
      lit_b(20'h7FFF8, 2'd0, 16'h7fff, 0);

      // Full throughput: no bubble on arg_ready, continuous results once filled.
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         a_arg_valid = 1; a_arg_data = 17'(i * 4099); a_arg_mode = 2'(i);
         @(negedge clock);
         check("tp_ready", a_arg_ready, 1);
         if (i >= 2) check("tp_valid", a_res_valid, 1);
      end
      @(posedge clock); #1 a_arg_valid = 0;
      drain(0);

      // Backpressure: two accepted, third refused until res_ready returns.
      a_res_ready = 0;
      @(posedge clock); #1;
      a_arg_valid = 1; a_arg_data = 17'h00123; a_arg_mode = 0;
      @(negedge clock); check("bp_ready1", a_arg_ready, 1);
      @(posedge clock); #1 a_arg_data = 17'h1fedc;
      @(negedge clock); check("bp_ready2", a_arg_ready, 1);
      @(posedge clock); #1 a_arg_data = 17'h0abcd;
      @(negedge clock);
      check("bp_ready3", a_arg_ready, 0);
      check("bp_head", a_res_data, 16'h0123);
      repeat (3) begin
         @(negedge clock); check("bp_hold_ready", a_arg_ready, 0);
      end
      @(posedge clock); #1 a_res_ready = 1;
      @(negedge clock);
      check("bp_release_ready", a_arg_ready, 1);
      check("bp_release_data", a_res_data, 16'h0123);
      @(posedge clock); #1 a_arg_valid = 0;
      drain(0);

      // Reset with two items in flight.
      a_res_ready = 0;
      @(posedge clock); #1;
      a_arg_valid = 1; a_arg_data = 17'h00555; a_arg_mode = 0;
      @(posedge clock); #1 a_arg_data = 17'h00666;
      @(posedge clock); #1 a_arg_valid = 0;
      @(negedge clock); check("pre_rst_ready", a_arg_ready, 0);
      @(posedge clock); #1 reset = 1;
      @(posedge clock); #1 begin reset = 0; a_res_ready = 1; end
      @(negedge clock);
      check("post_rst_valid", a_res_valid, 0);
      check("post_rst_ready", a_arg_ready, 1);
      check("post_rst_flag", a_sat_flag, 0);
      check("post_rst_count", a_sat_count, 0);
      repeat (4) begin
         @(negedge clock); check("post_rst_stale", a_res_valid, 0);
      end

      // Statistics on B (CW=2).
      repeat (5) lit_b(20'h7FFF8, 2'd1, 16'h7fff, 1);
      @(negedge clock);
      check("st_count_sat", b_sat_count, 3);
      check("st_flag", b_sat_flag, 1);
      @(posedge clock); #1 b_clear = 1;
      @(posedge clock); #1 b_clear = 0;
      @(negedge clock);
      check("st_clear_count", b_sat_count, 0);
      check("st_clear_flag", b_sat_flag, 0);
      repeat (2) lit_b(20'h7FFF8, 2'd1, 16'h7fff, 1);
      @(negedge clock); check("st_count2", b_sat_count, 2);
      @(posedge clock); #1;
      b_arg_valid = 1; b_arg_data = 20'h7FFF8; b_arg_mode = 2'd1;
      @(posedge clock); #1 b_arg_valid = 0;
      @(posedge clock); #1 b_clear = 1;
      @(posedge clock); #1 b_clear = 0;
      @(negedge clock);
      check("st_clear_evt_count", b_sat_count, 1);
      check("st_clear_evt_flag", b_sat_flag, 1);

      burst_a(40);
      burst_b(40);

      repeat (2) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/saturate_pipe.md
Name: saturate_pipe

Overview:
Parametrised, pipelined successor to the combinational 17→16 saturator. It takes a signed wide value, optionally right-shifts it with a selectable rounding mode, and saturates it to a narrower signed width. A valid/ready stream interface lets it sit between accumulator outputs and activation/storage stages. It also reports per-result saturation and keeps sticky and counted saturation statistics.

Parameters:
IW, 17, input width (signed two's complement)
OW, 16, output width (signed); IW-FRAC >= OW required (elaboration-time assertion)
FRAC, 0, number of LSBs discarded by the rounding shift; 0 means no rounding
CW, 8, width of saturation event counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
arg_valid  input  1  input value present
arg_ready  output  1  block accepts input this cycle
arg_data  input  IW  signed input value
arg_mode  input  2  rounding mode, sampled with arg_data on acceptance
res_valid  output  1  result present
res_ready  input  1  downstream accepts result
res_data  output  OW  rounded, saturated result
res_sat  output  1  this result was clamped
clear  input  1  clears sat_flag and sat_count
sat_flag  output  1  sticky: some delivered result was clamped
sat_count  output  CW  number of delivered clamped results, saturating

Behaviour:
- Reset: res_valid=0, internal stage-1 valid=0, res_data=0, res_sat=0, sat_flag=0, sat_count=0. Reset mid-operation flushes both stages; in-flight data is discarded.
- Handshake: a transfer happens when valid&&ready on the same edge. s2_en = !res_valid || res_ready; s1_en = !s1_valid || s2_en; arg_ready = s1_en. arg_ready is combinational from res_ready; no bubble at full throughput (1 result/cycle). Outputs stay stable while res_valid && !res_ready.
- Latency: 2 cycles from input acceptance to res_valid, given no backpressure. Capacity is 2 in-flight items. Results are delivered in order.
- Stage 1 (round): computes r = floor((x + bias) / 2^FRAC) at width IW-FRAC+1, so no wrap is possible.
  - mode 0 truncate: bias=0 (floor toward −inf).
  - mode 1 round-half-up: bias=2^(FRAC-1).
  - mode 2 round-half-even: bias=2^(FRAC-1), minus 1 when the kept LSB is 0 and the discarded bits equal exactly the half value.
  - mode 3 is reserved and behaves as mode 0.
  - FRAC=0: all modes give r=x.
- Stage 2 (saturate): if r > 2^(OW-1)-1, output max and set res_sat=1. If r < -2^(OW-1), output min and set res_sat=1. Otherwise output r[OW-1:0] with res_sat=0.
- Statistics update only on an output transfer (res_valid&&res_ready&&res_sat):
  - sat_flag is set to 1.
  - sat_count increments and holds at 2^CW-1.
  - clear without an event: flag=0, count=0.
  - clear with a simultaneous event: flag=1, count=1.
- The block does not check arg_data or arg_mode when arg_valid=0.

Decomposition:
- Package saturate_pkg holds the round_mode_t enum (ROUND_TRUNC=0, ROUND_HALF_UP=1, ROUND_HALF_EVEN=2, ROUND_RSVD=3).
- One combinational sub-module, round_shift, parametrised by IW and FRAC, implements the stage-1 arithmetic. Saturation is inline in stage 2.

Test Plan:
- Defaults, res_ready=1, mode 0. Inputs 17'h000ff, 17'h1ff00, 17'h07fff, 17'h10000 → outputs 16'h00ff, 16'hff00, 16'h7fff, 16'h8000 each 2 cycles after acceptance, res_sat=0,0,0,1.
- IW=20, FRAC=4. Input 20'h00018 (1.5) → 0x0001/0x0002/0x0002 for modes 0/1/2. Input 20'h00028 (2.5) → 0x0002/0x0003/0x0002. Input 20'hFFFE8 (−1.5) → 0xFFFE/0xFFFF/0xFFFE.
- IW=20, FRAC=4, mode 1. Input 20'h7FFF8 → res_data=16'h7fff, res_sat=1 (rounding overflow clamps). Mode 0 on the same input → 16'h7fff, res_sat=0.
- Backpressure: hold res_ready=0 and offer 3 inputs → the first two are accepted and arg_ready=0 on the third. Releasing res_ready drains all three in order with no loss or duplication. res_data stays stable while stalled.
- CW=2: deliver 5 clamped results → sat_count=3 and sat_flag=1. Pulse clear alone → 0/0. Pulse clear together with a clamped delivery → count=1, flag=1.
- Assert reset with 2 items in flight → next cycle res_valid=0, arg_ready=1, statistics zero, and no stale result appears afterwards.
